// File: rtl/crossbar_pkg.sv
// crossbar_pkg: default sizes and the route-table entry shared by the crossbar.
// The sel field is wide enough for any port count up to 256.
package crossbar_pkg;
  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;
  localparam int SEL_MAX_W  = 8;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel;
    logic                 en;
  } route_t;
endpackage

// File: rtl/crossbar_out_stage.sv
// crossbar_out_stage: one registered output port with valid/ready handshake.
// The parent only asserts load when can_acc is high.
module crossbar_out_stage
  import crossbar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              can_acc
);

  assign can_acc = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/crossbar_nxn_reg.sv
// crossbar_nxn_reg: NxN routed crossbar with registered outputs and multicast.
// Define CROSSBAR_PERF_CNT_EN to add per-output beat counters (cnt_clr, perf_cnt).
module crossbar_nxn_reg
  import crossbar_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_port,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic                cfg_en,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  output logic [N-1:0]        in_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready
`ifdef CROSSBAR_PERF_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [N*CNT_W-1:0]  perf_cnt
`endif
);

  if (N < 2 || N > (1 << SEL_MAX_W) ||
      (N & (N - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("crossbar_nxn_reg: bad parameters");
  end

  route_t              rt [N];
  logic [N-1:0]        can_acc;
  logic [N-1:0]        hit;
  logic [N-1:0]        blk;
  logic [N-1:0]        fire;
  logic [N-1:0]        ld;
  logic [N*DATA_W-1:0] ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N; o++) begin
        rt[o].sel <= SEL_MAX_W'(o);
        rt[o].en  <= 1'b1;
      end
    end else if (cfg_we) begin
      rt[cfg_port].sel <= SEL_MAX_W'(cfg_sel);
      rt[cfg_port].en  <= cfg_en;
    end
  end

  // An input is ready only when every enabled destination can take the beat.
  always_comb begin
    hit = '0;
    blk = '0;
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < N; o++) begin
        if (rt[o].en && rt[o].sel == SEL_MAX_W'(i)) begin
          hit[i] = 1'b1;
          if (!can_acc[o]) blk[i] = 1'b1;
        end
      end
    end
  end

  assign in_ready = hit & ~blk & {N{rst_n}};
  assign fire     = in_valid & in_ready;

  always_comb begin
    ld      = '0;
    ld_data = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        if (rt[o].sel == SEL_MAX_W'(i)) begin
          ld[o] = rt[o].en && fire[i];
          ld_data[o*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar o = 0; o < N; o++) begin : g_out
    crossbar_out_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld[o]),
      .load_data(ld_data[o*DATA_W +: DATA_W]),
      .out_ready(out_ready[o]),
      .out_valid(out_valid[o]),
      .out_data (out_data[o*DATA_W +: DATA_W]),
      .can_acc  (can_acc[o])
    );
  end

`ifdef CROSSBAR_PERF_CNT_EN
  for (genvar o = 0; o < N; o++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (out_valid[o] && out_ready[o] && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign perf_cnt[o*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_crossbar_nxn_reg.sv
// tb_crossbar_nxn_reg: directed vector table plus hand-written corner sequences.
// Runs with N=4, DATA_W=16, CNT_W=4.
module tb_crossbar_nxn_reg;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_port = '0;
  logic [1:0]    cfg_sel = '0;
  logic          cfg_en = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
`ifdef CROSSBAR_PERF_CNT_EN
  logic          cnt_clr = 1'b0;
  logic [N*CW-1:0] perf_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  crossbar_nxn_reg #(
    .N(N), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_port (cfg_port),
    .cfg_sel  (cfg_sel),
    .cfg_en   (cfg_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef CROSSBAR_PERF_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .perf_cnt (perf_cnt)
`endif
  );

  typedef struct {
    logic [N-1:0]    iv;
    logic [N*DW-1:0] id;
    logic [N-1:0]    ordy;
    logic [N-1:0]    x_irdy;
    logic [N-1:0]    x_ov;
    logic [N*DW-1:0] x_od;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int p, int s, logic e);
    cfg_we   = 1'b1;
    cfg_port = 2'(p);
    cfg_sel  = 2'(s);
    cfg_en   = e;
    tick();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [DW-1:0] lane(int o);
    return out_data[o*DW +: DW];
  endfunction

  int exp_seq [N];
  int oerr;
  int stall;

  initial begin
    tbl[0] = '{4'b1111, 64'h00A3_00A2_00A1_00A0, 4'b1111,
               4'b1111, 4'b1111, 64'h00A3_00A2_00A1_00A0};
    tbl[1] = '{4'b0101, 64'h00B3_00B2_00B1_00B0, 4'b1111,
               4'b1111, 4'b0101, 64'h00A3_00B2_00A1_00B0};
    tbl[2] = '{4'b1111, 64'h00C3_00C2_00C1_00C0, 4'b0000,
               4'b1010, 4'b1111, 64'h00C3_00B2_00C1_00B0};
    tbl[3] = '{4'b0000, 64'h0, 4'b0011,
               4'b0011, 4'b1100, 64'h00C3_00B2_00C1_00B0};
    tbl[4] = '{4'b1111, 64'h00D3_00D2_00D1_00D0, 4'b0000,
               4'b0011, 4'b1111, 64'h00C3_00B2_00D1_00D0};
    tbl[5] = '{4'b0000, 64'h0, 4'b1111,
               4'b1111, 4'b0000, 64'h00C3_00B2_00D1_00D0};

    // reset state, in_valid held high during reset
    in_valid = 4'b1111;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    tick();
    tick();
    in_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'hF);

    // identity routing table
    for (int k = 0; k < 6; k++) begin
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].id;
      out_ready = tbl[k].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", k), 64'(in_ready),
          64'(tbl[k].x_irdy));
      tick();
      chk($sformatf("v%0d_out_valid", k), 64'(out_valid),
          64'(tbl[k].x_ov));
      chk($sformatf("v%0d_out_data", k), out_data, tbl[k].x_od);
    end

    // multicast: outputs 0,1,2 from input 1; output 2 stalls
    cfg(0, 1, 1'b1);
    cfg(2, 1, 1'b1);
    in_valid  = 4'b0010;
    in_data   = 64'h0000_0000_0011_0000;
    out_ready = 4'b1011;
    #1;
    chk("mc_first_ready", 64'(in_ready[1]), 64'h1);
    tick();
    chk("mc_first_valid", 64'(out_valid), 64'h7);
    in_data = 64'h0000_0000_0022_0000;
    #1;
    chk("mc_blocked_ready", 64'(in_ready[1]), 64'h0);
    tick();
    chk("mc_blocked_valid", 64'(out_valid), 64'h4);
    chk("mc_held_lane2", 64'(lane(2)), 64'h11);
    out_ready = 4'b1111;
    #1;
    chk("mc_unblock_ready", 64'(in_ready[1]), 64'h1);
    tick();
    chk("mc_both_valid", 64'(out_valid), 64'h7);
    chk("mc_lane0", 64'(lane(0)), 64'h22);
    chk("mc_lane2", 64'(lane(2)), 64'h22);
    in_valid = '0;
    tick();

    // unrouted input 3
    cfg(3, 3, 1'b0);
    in_valid = 4'b1000;
    in_data  = 64'h0033_0000_0000_0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("unr_in_ready", 64'(in_ready[3]), 64'h0);
      tick();
      chk("unr_out_valid", 64'(out_valid[3]), 64'h0);
    end
    cfg_we   = 1'b1;
    cfg_port = 2'd3;
    cfg_sel  = 2'd3;
    cfg_en   = 1'b1;
    #1;
    chk("unr_old_table", 64'(in_ready[3]), 64'h0);
    tick();
    cfg_we = 1'b0;
    #1;
    chk("unr_reenabled", 64'(in_ready[3]), 64'h1);
    tick();
    chk("unr_beat_valid", 64'(out_valid[3]), 64'h1);
    chk("unr_beat_data", 64'(lane(3)), 64'h33);
    in_valid = '0;
    tick();

    // config/fire race on output 0
    cfg(0, 0, 1'b1);
    cfg(2, 2, 1'b1);
    in_valid = 4'b0001;
    in_data  = 64'h0000_0000_0000_0055;
    cfg_we   = 1'b1;
    cfg_port = 2'd0;
    cfg_sel  = 2'd2;
    cfg_en   = 1'b1;
    #1;
    chk("race_in_ready0", 64'(in_ready[0]), 64'h1);
    tick();
    cfg_we = 1'b0;
    chk("race_lane0", 64'(lane(0)), 64'h55);
    in_valid = 4'b0101;
    in_data  = 64'h0000_0077_0000_0066;
    #1;
    chk("race_in0_unrouted", 64'(in_ready[0]), 64'h0);
    tick();
    chk("race_next_lane0", 64'(lane(0)), 64'h77);
    chk("race_next_lane2", 64'(lane(2)), 64'h77);
    in_valid = '0;
    cfg(0, 0, 1'b1);
    tick();

    // streaming: 100 back-to-back beats per port
    oerr  = 0;
    stall = 0;
    for (int o = 0; o < N; o++) exp_seq[o] = 0;
    for (int k = 0; k < 100; k++) begin
      in_valid = 4'b1111;
      for (int i = 0; i < N; i++)
        in_data[i*DW +: DW] = {8'(i), 8'(k)};
      #1;
      if (in_ready != 4'b1111) stall++;
      tick();
      for (int o = 0; o < N; o++) begin
        if (out_valid[o]) begin
          if (lane(o) == {8'(o), 8'(exp_seq[o])}) exp_seq[o]++;
          else oerr++;
        end
      end
    end
    in_valid = '0;
    for (int o = 0; o < N; o++)
      chk($sformatf("stream_cnt%0d", o), 64'(exp_seq[o]), 64'd100);
    chk("stream_order", 64'(oerr), 64'h0);
    chk("stream_stall", 64'(stall), 64'h0);
    tick();
    tick();

`ifdef CROSSBAR_PERF_CNT_EN
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clear0", 64'(perf_cnt[CW +: CW]), 64'h0);
    in_valid = 4'b0010;
    repeat (10) tick();
    chk("cnt_mid", 64'(perf_cnt[CW +: CW]), 64'd9);
    repeat (10) tick();
    chk("cnt_sat", 64'(perf_cnt[CW +: CW]), 64'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_override", 64'(perf_cnt[CW +: CW]), 64'h0);
    in_valid = '0;
    tick();
    chk("cnt_after_clr", 64'(perf_cnt[CW +: CW]), 64'h1);
    tick();
`endif

    // asynchronous reset with held beats
    in_valid  = 4'b1111;
    in_data   = 64'h00E3_00E2_00E1_00E0;
    out_ready = 4'b0000;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_data", out_data, 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crossbar_nxn_reg.md
CROSSBAR_NXN_REG -- requirements
Module: crossbar_nxn_reg

Interface
REQ-001 SHALL have parameter N, default 4, number of input ports and number of output ports (N >= 2, power of two).
REQ-002 SHALL have parameter DATA_W, default 64, width of each port's data.
REQ-003 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-004 SHALL derive localparam SEL_W = clog2(N).
REQ-005 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: cfg_we  input  1  route-table write strobe.
REQ-008 Port: cfg_port  input  SEL_W  output index being written.
REQ-009 Port: cfg_sel  input  SEL_W  source input index for that output.
REQ-010 Port: cfg_en  input  1  enable for that output.
REQ-011 Port: in_data  input  N*DATA_W  input i occupies bits [i*DATA_W +: DATA_W].
REQ-012 Port: in_valid / in_ready  input / output  N  per-input handshake.
REQ-013 Port: out_data  output  N*DATA_W  registered output data, same packing as in_data.
REQ-014 Port: out_valid / out_ready  output / input  N  per-output handshake.

Function
REQ-015 Route table SHALL hold sel[o] and en[o] per output; a cfg_we write SHALL take effect on the following cycle.
REQ-016 can_acc[o] SHALL equal !out_valid[o] || out_ready[o].
REQ-017 in_ready[i] SHALL be 1 only if at least one enabled output selects i and every enabled output selecting i has can_acc set; it SHALL not depend on in_valid[i].
REQ-018 fire[i] SHALL equal in_valid[i] && in_ready[i]; a multicast beat SHALL load all its destination outputs in the same cycle, never a subset.
REQ-019 An output whose source fires SHALL load its data and set out_valid on the next edge (1-cycle latency).
REQ-020 An output with out_valid && out_ready and no loading source SHALL clear out_valid.
REQ-021 out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 Full throughput SHALL be sustained: one beat per cycle per output when out_ready stays high.
REQ-023 An input that no enabled output selects SHALL see in_ready=0 and stall; beats SHALL never be dropped.
REQ-024 If cfg_we and fire occur in the same cycle, fire SHALL use the old table.
REQ-025 A route change SHALL NOT alter beats already held in output registers.

Reset
REQ-026 On reset, sel[o] SHALL be o, en[o] SHALL be 1, out_valid SHALL be 0, and out_data SHALL be 0.
REQ-027 On reset, in_ready SHALL be 0 while rst_n is low.
REQ-028 Reset asserted mid-transfer SHALL discard held beats immediately, without waiting for a clock edge.

Configuration
REQ-029 With macro CROSSBAR_PERF_CNT_EN defined, the block SHALL add an input cnt_clr (1 bit) and an output perf_cnt (N*CNT_W bits).
REQ-030 With CROSSBAR_PERF_CNT_EN defined, perf_cnt[o] SHALL increment on each out_valid[o] && out_ready[o] beat and saturate at all-ones.
REQ-031 With CROSSBAR_PERF_CNT_EN defined, cnt_clr SHALL zero all counters and override any increment in the same cycle; counters SHALL reset to 0.
REQ-032 Without CROSSBAR_PERF_CNT_EN, those ports and that logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-033 Package crossbar_pkg SHALL hold the default N, DATA_W and CNT_W values and the route-entry typedef (sel, en).
REQ-034 Each output register and its handshake SHALL be a sub-module crossbar_out_stage, instantiated N times.

Verification
REQ-035 Bench SHALL check reset identity routing: after reset, drive in_valid=4'b1111 with in_data lanes 0xA0..0xA3 and all out_ready=1 -> next cycle out_valid=4'b1111 with out_data lane o = 0xA0+o.
REQ-036 Bench SHALL check multicast backpressure: route outputs 0 and 2 to input 1, hold out_valid[2]=1 with out_ready[2]=0 -> in_ready[1]=0 and output 0 not loaded; raise out_ready[2] -> both outputs load in the same cycle.
REQ-037 Bench SHALL check an unrouted input: disable all routes to input 3 -> in_ready[3]=0 indefinitely, and its beat appears one cycle after re-enabling a route.
REQ-038 Bench SHALL check a config/fire race: write sel[0]=2 in the same cycle input 0 fires 0x55 -> out_data lane 0 = 0x55; the next beat on output 0 comes from input 2.
REQ-039 Bench SHALL check streaming: out_ready held high with 100 back-to-back beats per port -> 100 beats out in 100 cycles, in order, with no duplicates.
REQ-040 Bench SHALL check counters: with CNT_W=4 and 20 beats on output 1 -> perf_cnt[1]=15 (saturated); asserting cnt_clr -> 0 the next cycle.
